// File: rtl/pokey_pkg.sv
// Shared constants for the POKEY-style up counters: default width and an
// all-ones mask helper so every counter derives its wrap value the same way.
package pokey_pkg;

    localparam int UPCNT_WIDTH = 8;

    // All-ones mask of w bits, right-aligned in a 64-bit word.
    function automatic logic [63:0] all_ones(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pokey_inc_cell.sv
// One bit of the ripple up counter: toggles when carry-in is high,
// takes ld_val_i when ld_i is high, and passes carry on while the bit is set.
module pokey_inc_cell (
    input  logic clk,
    input  logic nrst,
    input  logic ld_i,
    input  logic ld_val_i,
    input  logic ci_i,
    output logic co_o,
    output logic q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (ld_i) begin
            bit_d = ld_val_i;
        end else if (ci_i) begin
            bit_d = ~bit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign co_o = ci_i & bit_q;
    assign q_o  = bit_q;

endmodule

// File: rtl/pokey_up_counter.sv
// POKEY-style chainable up counter that reloads din on wrap instead of zero.
// Define POKEY_UPCNT_STICKY_EN to add the sticky overflow flag (irq_clr/irq_st).
module pokey_up_counter
    import pokey_pkg::*;
#(
    parameter int WIDTH = UPCNT_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enp,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             link,
    input  logic             cin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf
`ifdef POKEY_UPCNT_STICKY_EN
    ,
    input  logic             irq_clr,
    output logic             irq_st
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic             advance;
    logic             at_top;
    logic             wrap_hit;
    logic             cell_ld;
    logic [WIDTH:0]   chain;
    logic             ovf_q;
    logic             ovf_d;

    assign advance  = enp & (link ? cin : 1'b1);
    assign at_top   = (q == ALL_ONES);
    assign wrap_hit = advance & at_top;
    // A wrap reloads din through the same path as an explicit load.
    assign cell_ld  = load | wrap_hit;
    assign chain[0] = advance;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        pokey_inc_cell u_cell (
            .clk      (clk),
            .nrst     (nrst),
            .ld_i     (cell_ld),
            .ld_val_i (din[i]),
            .ci_i     (chain[i]),
            .co_o     (chain[i+1]),
            .q_o      (q[i])
        );
    end

    assign cout  = chain[WIDTH];
    assign ovf_d = wrap_hit & ~load;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef POKEY_UPCNT_STICKY_EN
    logic irq_st_q;
    logic irq_st_d;

    // Set wins over a simultaneous clear so no wrap is ever lost.
    always_comb begin
        irq_st_d = irq_st_q;
        if (ovf_d) begin
            irq_st_d = 1'b1;
        end else if (irq_clr) begin
            irq_st_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            irq_st_q <= 1'b0;
        end else begin
            irq_st_q <= irq_st_d;
        end
    end

    assign irq_st = irq_st_q;
`endif

endmodule

// File: doc/pokey_up_counter.md
POKEY_UP_COUNTER -- requirements
Module: pokey_up_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, counter width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: nrst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: enp  input  1  advance enable, one-cycle strobe from the prescaler.
REQ-005 SHALL have port: load  input  1  force reload of q from din.
REQ-006 SHALL have port: din  input  WIDTH  reload value (wrap target).
REQ-007 SHALL have port: link  input  1  1 = chained mode; advance also requires cin.
REQ-008 SHALL have port: cin  input  1  carry from the lower-order counter.
REQ-009 SHALL have port: q  output  WIDTH  current count.
REQ-010 SHALL have port: cout  output  1  combinational carry to the next-higher counter.
REQ-011 SHALL have port: ovf  output  1  registered one-cycle wrap pulse.

Function
REQ-012 SHALL define advance = enp & (link ? cin : 1).
REQ-013 SHALL, on load=1 at the clock edge, set q <= din regardless of advance; load has priority.
REQ-014 SHALL, on advance=1, load=0, q != all-ones, set q <= q+1, modulo 2^WIDTH, no other side effect.
REQ-015 SHALL, on advance=1, load=0, q == all-ones, set q <= din (wrap reload, not 0).
REQ-016 SHALL hold q when advance=0 and load=0.
REQ-017 SHALL drive cout = advance & (q == all-ones) combinationally, zero-latency, so chained counters advance in the same cycle.
REQ-018 SHALL assert ovf for exactly one cycle, on the edge after a wrap per REQ-015; no ovf when load coincides with the wrap condition.
REQ-019 SHALL, with din == all-ones, wrap every advance: ovf pulses once per advance.
REQ-020 SHALL ignore cin when link=0; link may change any cycle and takes effect on the same edge.

Reset
REQ-021 SHALL, when nrst=0 at a posedge, clear q to 0 and ovf to 0 (and irq_st per REQ-024); reset overrides load and advance.
REQ-022 SHALL keep cout combinational; during reset cout follows REQ-017 with the pre-reset q.

Configuration
REQ-023 SHALL compile a sticky overflow flag only when macro POKEY_UPCNT_STICKY_EN is defined.
REQ-024 SHALL, with POKEY_UPCNT_STICKY_EN, add ports irq_clr input 1 and irq_st output 1: irq_st sets on the wrap edge, clears on irq_clr, set wins on simultaneous set/clear, reset value 0.
REQ-025 SHALL, without POKEY_UPCNT_STICKY_EN, omit irq_clr and irq_st entirely; all other behaviour is identical.

Structure
REQ-026 SHALL take the WIDTH default (8) and an all-ones count constant from shared package pokey_pkg.
REQ-027 SHALL build q from WIDTH instances of sub-module pokey_inc_cell: one bit flip-flop with load value, carry-in, carry-out = carry-in & bit, toggle on carry-in; cell 0 carry-in = advance.
REQ-028 SHALL derive cout from the last cell's carry-out.

Verification
REQ-029 SHALL cover free-run: nrst released, load din=8'hFC, link=0, enp every cycle -> q FC,FD,FE,FF,FC; cout high with q=FF; ovf high one cycle after.
REQ-030 SHALL cover chaining: two instances, low cout -> high cin, high link=1, both din=0, loaded 0 -> high q increments only when low q goes FF->00; high q=01 after 256 enp.
REQ-031 SHALL cover load vs wrap: q=FF, enp=1 and load=1 with din=8'h10 same cycle -> q=10, ovf stays 0.
REQ-032 SHALL cover reset mid-count: q=8'h7A, enp=1, nrst=0 for one edge -> q=00, ovf=0; counting resumes 01 after release.
REQ-033 SHALL cover gating: link=1, cin=0, enp=1 for 10 cycles -> q unchanged; link=0 -> advances next edge.
REQ-034 SHALL cover sticky (macro defined): wrap with irq_clr=1 same cycle -> irq_st=1; irq_clr alone next cycle -> irq_st=0.
